mem_arbiter: RTL

Arbitrates a single word-wide memory bus between the instruction-fetch requester (IF) and the data-access requester (MEM).
- Sequences each transaction on the bus and returns read data to the owning requester.
- Converts partial (byte-select) stores into read-modify-write, because the bus only accepts full-word writes.
- Drives the pipeline stall requests.
- Aborts hung transactions with a watchdog.
- Sits between the pipeline's IF/MEM stages and the external memory/bus interface.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/bus_watchdog.sv | 42 ++++
 rtl/mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-bus arbiter.
package mem_arbiter_pkg;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_IF_RD  = 3'd1,
        ARB_MEM_RD = 3'd2,
        ARB_RMW_RD = 3'd3,
        ARB_RMW_WR = 3'd4,
        ARB_MEM_WR = 3'd5
    } arb_state_e;

    // Byte-select patterns with special handling.
    localparam logic [3:0] SEL_FULL = 4'b1111;
    localparam logic [3:0] SEL_NONE = 4'b0000;

    // Default number of un-acked bus cycles before abort.
    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_watchdog.sv
// Bus watchdog: counts un-acked bus cycles and flags the cycle in which
// the count reaches TIMEOUT, so the owner can abort on that edge.
module bus_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clear has priority over counting.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expires in the cycle whose un-acked increment would reach TIMEOUT.
    assign expired_o = en_i && !clear_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and data
// access, turning partial stores into read-modify-write sequences.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [DATA_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    output logic              stall_req_if,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ack_o,
    output logic              stall_req_mem,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [DATA_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic              last_mem_q, last_mem_d;
    logic              bus_ce_q, bus_ce_d;
    logic              bus_we_q, bus_we_d;
    logic [DATA_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_ack_q, mem_ack_d;
    logic              err_q, err_d;

    logic              bus_ack;
    logic              wd_clear;
    logic              wd_expired;
    logic              go_idle;
    logic              if_elig, mem_elig;
    logic              grant_if, grant_mem;
    logic [DATA_W-1:0] merge_word;

    // An ack only counts while a bus cycle is actually being presented.
    assign bus_ack = bus_ack_i & bus_ce_q;

    // A requester whose ack is going out this cycle must not be re-granted.
    assign if_elig   = if_req_i & ~if_ack_q;
    assign mem_elig  = mem_req_i & ~mem_ack_q;
    assign grant_mem = mem_elig & (~if_elig | ~last_mem_q);
    assign grant_if  = if_elig & ~grant_mem;

    // Partial-store merge: selected bytes from the store data, rest from memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merge_word[8*gi +: 8] = sel_q[gi] ? wdata_q[8*gi +: 8]
                                                     : bus_data_i[8*gi +: 8];
        end
    endgenerate

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (wd_clear),
        .en_i     (bus_ce_q & ~bus_ack_i),
        .expired_o(wd_expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        last_mem_d = last_mem_q;
        bus_ce_d   = bus_ce_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        if_data_d  = '0;
        if_ack_d   = 1'b0;
        mem_data_d = '0;
        mem_ack_d  = 1'b0;
        err_d      = 1'b0;
        wd_clear   = 1'b0;
        go_idle    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                bus_ce_d   = 1'b0;
                bus_we_d   = 1'b0;
                bus_addr_d = '0;
                bus_data_d = '0;
                if (grant_mem) begin
                    last_mem_d = 1'b1;
                    addr_d     = mem_addr_i;
                    wdata_d    = mem_data_i;
                    sel_d      = mem_sel_i;
                    wd_clear   = 1'b1;
                    if (!mem_we_i) begin
                        state_d    = ARB_MEM_RD;
                        bus_ce_d   = 1'b1;
                        bus_addr_d = mem_addr_i;
                    end else if (mem_sel_i == SEL_FULL) begin
                        state_d    = ARB_MEM_WR;
                        bus_ce_d   = 1'b1;
                        bus_we_d   = 1'b1;
                        bus_addr_d = mem_addr_i;
                        bus_data_d = mem_data_i;
                    end else if (mem_sel_i == SEL_NONE) begin
                        // Nothing to write: complete without touching the bus.
                        mem_ack_d = 1'b1;
                    end else begin
                        state_d    = ARB_RMW_RD;
                        bus_ce_d   = 1'b1;
                        bus_addr_d = mem_addr_i;
                    end
                end else if (grant_if) begin
                    last_mem_d = 1'b0;
                    addr_d     = if_addr_i;
                    wd_clear   = 1'b1;
                    state_d    = ARB_IF_RD;
                    bus_ce_d   = 1'b1;
                    bus_addr_d = if_addr_i;
                end
            end
            ARB_IF_RD: begin
                if (bus_ack) begin
                    if_data_d = bus_data_i;
                    if_ack_d  = 1'b1;
                    go_idle   = 1'b1;
                end else if (wd_expired) begin
                    if_ack_d = 1'b1;
                    err_d    = 1'b1;
                    go_idle  = 1'b1;
                end
            end
            ARB_MEM_RD: begin
                if (bus_ack) begin
                    mem_data_d = bus_data_i;
                    mem_ack_d  = 1'b1;
                    go_idle    = 1'b1;
                end else if (wd_expired) begin
                    mem_ack_d = 1'b1;
                    err_d     = 1'b1;
                    go_idle   = 1'b1;
                end
            end
            ARB_RMW_RD: begin
                if (bus_ack) begin
                    // Drop the bus for one cycle, then issue the merged write.
                    wdata_d  = merge_word;
                    state_d  = ARB_RMW_WR;
                    bus_ce_d = 1'b0;
                    wd_clear = 1'b1;
                end else if (wd_expired) begin
                    mem_ack_d = 1'b1;
                    err_d     = 1'b1;
                    go_idle   = 1'b1;
                end
            end
            ARB_RMW_WR, ARB_MEM_WR: begin
                if (!bus_ce_q) begin
                    // Gap cycle after the RMW read phase.
                    bus_ce_d   = 1'b1;
                    bus_we_d   = 1'b1;
                    bus_addr_d = addr_q;
                    bus_data_d = wdata_q;
                end else if (bus_ack) begin
                    mem_ack_d = 1'b1;
                    go_idle   = 1'b1;
                end else if (wd_expired) begin
                    mem_ack_d = 1'b1;
                    err_d     = 1'b1;
                    go_idle   = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (go_idle) begin
            state_d    = ARB_IDLE;
            bus_ce_d   = 1'b0;
            bus_we_d   = 1'b0;
            bus_addr_d = '0;
            bus_data_d = '0;
        end
    end

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            last_mem_q <= 1'b0;
            bus_ce_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            if_data_q  <= '0;
            if_ack_q   <= 1'b0;
            mem_data_q <= '0;
            mem_ack_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            last_mem_q <= last_mem_d;
            bus_ce_q   <= bus_ce_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            if_data_q  <= if_data_d;
            if_ack_q   <= if_ack_d;
            mem_data_q <= mem_data_d;
            mem_ack_q  <= mem_ack_d;
            err_q      <= err_d;
        end
    end

    assign if_data_o     = if_data_q;
    assign if_ack_o      = if_ack_q;
    assign mem_data_o    = mem_data_q;
    assign mem_ack_o     = mem_ack_q;
    assign bus_ce_o      = bus_ce_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_data_o    = bus_data_q;
    assign bus_err_o     = err_q;
    assign stall_req_if  = if_req_i & ~if_ack_q;
    assign stall_req_mem = mem_req_i & ~mem_ack_q;

endmodule
